notch_coeff_loader: RTL and testbench
=====================================

NOTCH_COEFF_LOADER -- requirements
Module: notch_coeff_loader

Interface
Parameters (one per line: name, default, meaning):
REQ-001 width, 16, coefficient and APB data width in bits; the filter coefficient format is S16.14.

Ports (one per line: name, direction, width, meaning; clock and reset first):
REQ-002 CLK  input  1  single clock for all logic.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PSEL  input  1  APB select.
REQ-005 PENABLE  input  1  APB access phase.
REQ-006 PWRITE  input  1  APB write (1) or read (0).
REQ-007 PADDR  input  5  register index (not a byte address).
REQ-008 PWDATA  input  width  APB write data.
REQ-009 PRDATA  output  width  APB read data.
REQ-010 PREADY  output  1  APB ready; held at 1 (zero wait states).
REQ-011 PSLVERR  output  1  APB error; valid in the access phase only.
REQ-012 sample_strobe  input  1  one-cycle pulse marking a filter sample boundary.
REQ-013 coeff_1  output  5*width  stage-1 active coefficients, packed {b0,b1,b2,a1,a2}, with b0 in the MSBs.
REQ-014 coeff_2  output  5*width  stage-2 active coefficients, same packing as coeff_1.
REQ-015 EN  output  1  filter enable to both stages.
REQ-016 bypass_1, bypass_2  output  1 each  per-stage bypass.
REQ-017 commit_done  output  1  one-cycle pulse when the shadow registers are copied to the active registers.

Function
REQ-018 Register map:
- 0x00-0x04: stage-1 shadow b0,b1,b2,a1,a2.
- 0x05-0x09: stage-2 shadow b0,b1,b2,a1,a2.
- 0x0A: CTRL, with bit0 EN, bit1 bypass_1, bit2 bypass_2; bits 15:3 read 0.
- 0x0B: COMMIT; a write with bit0=1 requests a commit; a read returns {15'b0, pending}.
- 0x0C: CCOUNT, read-only, 8-bit commit counter zero-extended to width.
REQ-019 An APB access occurs on a cycle with PSEL=1 and PENABLE=1; writes take effect at that clock edge.
REQ-020 PRDATA is combinational during the access phase and is 0 outside it.
REQ-021 Shadow coefficient registers read back their shadow values, not the active values.
REQ-022 PSLVERR=1 in the access phase, with no state change and PRDATA=0, for any of:
- PADDR > 0x0C;
- a write to 0x0C;
- a write to 0x00-0x09 while pending=1.
REQ-023 CTRL writes take effect directly on EN, bypass_1 and bypass_2 on the following cycle; CTRL is not shadowed.
REQ-024 Commit state machine:
- States: IDLE and PENDING.
- IDLE -> PENDING on a COMMIT write with bit0=1.
- PENDING -> IDLE on the first sample_strobe=1 seen in a later cycle.
- A COMMIT write with bit0=0, or any COMMIT write while in PENDING, has no effect and no error.
REQ-025 On the PENDING -> IDLE edge:
- all ten shadow values are copied atomically to coeff_1 and coeff_2;
- commit_done=1 for exactly that following cycle;
- CCOUNT increments, wrapping from 0xFF to 0x00.
REQ-026 Latency: coeff outputs change on the clock edge that samples sample_strobe=1 in PENDING. A sample_strobe arriving in the same cycle as the COMMIT write does not commit.
REQ-027 A sample_strobe in IDLE leaves all outputs unchanged.
REQ-028 coeff_1 and coeff_2 change only on a commit; they never show a partial update.

Reset
REQ-029 While rst=1 at a clock edge, all registers take their reset values:
- shadow and active stage 1 = {0x4000,0x678E,0x4000,0x6473,0x3C38};
- shadow and active stage 2 = {0x4000,0xC000,0x4000,0xC1EC,0x3C38};
- EN=1, bypass_1=0, bypass_2=0;
- pending=0 (IDLE), CCOUNT=0, commit_done=0.
REQ-030 A reset asserted while PENDING discards the pending commit; the active coefficients return to the defaults and no commit_done is produced.
REQ-031 APB accesses during rst=1 are ignored; PSLVERR=0.

Verification
REQ-032 Reset -> coeff_1=0x4000678E400064733C38, coeff_2=0x4000C0004000C1EC3C38, EN=1, bypass_1=bypass_2=0, read of 0x0C returns 0.
REQ-033 Write 0x01=0x1234, then read 0x01 -> returns 0x1234, coeff_1 unchanged. Then COMMIT=1, then sample_strobe -> next cycle coeff_1[63:48]=0x1234, commit_done pulses for 1 cycle, CCOUNT=1.
REQ-034 COMMIT=1 and sample_strobe in the same cycle -> no commit. Next strobe 3 cycles later -> commit occurs, pending reads 0.
REQ-035 While pending, write 0x07=0xAAAA -> PSLVERR=1 and shadow unchanged. Accesses to PADDR=0x0D (read or write) and a write to 0x0C -> PSLVERR=1, PRDATA=0.
REQ-036 Write CTRL=0x0006 -> next cycle EN=0, bypass_1=1, bypass_2=1 with no commit required. 256 commits -> CCOUNT wraps to 0.
REQ-037 Set pending, assert rst for 1 cycle, then sample_strobe -> no commit_done, coefficients at defaults.

Source files
------------

// File: rtl/notch_coeff_loader.sv
// notch_coeff_loader
// APB-programmable coefficient bank for two cascaded biquad notch stages.
// Software writes shadow coefficients, then requests a commit; the shadow set
// is copied to the active set on the next filter sample boundary so the
// filter never sees a partially updated coefficient set.
module notch_coeff_loader #(
    parameter int width = 16
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [4:0]         PADDR,
    input  logic [width-1:0]   PWDATA,
    output logic [width-1:0]   PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic               sample_strobe,
    output logic [5*width-1:0] coeff_1,
    output logic [5*width-1:0] coeff_2,
    output logic               EN,
    output logic               bypass_1,
    output logic               bypass_2,
    output logic               commit_done
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Default coefficient set (S16.14), sign-extended to the data width.
    // Index 0-4 is stage 1 {b0,b1,b2,a1,a2}, index 5-9 is stage 2.
    function automatic logic [width-1:0] default_coeff(input logic [3:0] idx);
        logic [15:0] raw;
        case (idx)
            4'd0:    raw = 16'h4000;
            4'd1:    raw = 16'h678E;
            4'd2:    raw = 16'h4000;
            4'd3:    raw = 16'h6473;
            4'd4:    raw = 16'h3C38;
            4'd5:    raw = 16'h4000;
            4'd6:    raw = 16'hC000;
            4'd7:    raw = 16'h4000;
            4'd8:    raw = 16'hC1EC;
            4'd9:    raw = 16'h3C38;
            default: raw = 16'h0000;
        endcase
        return width'($signed(raw));
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [width-1:0] shadow_r [10];
    logic [width-1:0] active_r [10];
    logic             en_r;
    logic             byp1_r;
    logic             byp2_r;
    logic [7:0]       ccount_r;
    logic             done_r;

    logic             access_s;
    logic             err_s;
    logic [width-1:0] rdata_s;
    logic             wr_ok_s;
    logic             commit_req_s;
    logic             commit_s;

    // Accesses are ignored entirely while reset is held.
    assign access_s     = PSEL & PENABLE & ~rst;
    assign wr_ok_s      = access_s & PWRITE & ~err_s;
    assign commit_req_s = wr_ok_s & (PADDR == 5'd11) & PWDATA[0];

    // Address decode: error detection and combinational read mux.
    always_comb begin
        err_s   = 1'b0;
        rdata_s = {width{1'b0}};
        if (access_s) begin
            if (PADDR > 5'd12) begin
                err_s = 1'b1;
            end else if (PWRITE && (PADDR == 5'd12)) begin
                err_s = 1'b1;
            end else if (PWRITE && (PADDR < 5'd10) && (state_r == PENDING)) begin
                // Shadows are frozen until the pending commit lands.
                err_s = 1'b1;
            end else begin
                err_s = 1'b0;
            end
            if (!PWRITE && !err_s) begin
                case (PADDR)
                    5'd10:   rdata_s = {{(width-3){1'b0}}, byp2_r, byp1_r, en_r};
                    5'd11:   rdata_s = {{(width-1){1'b0}}, (state_r == PENDING)};
                    5'd12:   rdata_s = {{(width-8){1'b0}}, ccount_r};
                    default: begin
                        if (PADDR < 5'd10) begin
                            rdata_s = shadow_r[PADDR[3:0]];
                        end else begin
                            rdata_s = {width{1'b0}};
                        end
                    end
                endcase
            end else begin
                rdata_s = {width{1'b0}};
            end
        end else begin
            err_s   = 1'b0;
            rdata_s = {width{1'b0}};
        end
    end

    // Commit FSM next state: a strobe only commits once PENDING is registered,
    // so a strobe in the same cycle as the COMMIT write is ignored.
    always_comb begin
        state_next_s = state_r;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (commit_req_s) begin
                    state_next_s = PENDING;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PENDING: begin
                if (sample_strobe) begin
                    state_next_s = IDLE;
                    commit_s     = 1'b1;
                end else begin
                    state_next_s = PENDING;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Commit FSM state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow coefficient registers, written directly by software.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                shadow_r[i] <= default_coeff(4'(i));
            end
        end else if (wr_ok_s && (PADDR < 5'd10)) begin
            shadow_r[PADDR[3:0]] <= PWDATA;
        end
    end

    // Active coefficients, commit pulse and commit counter; all ten words move together.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                active_r[i] <= default_coeff(4'(i));
            end
            done_r   <= 1'b0;
            ccount_r <= 8'd0;
        end else begin
            done_r <= commit_s;
            if (commit_s) begin
                for (int i = 0; i < 10; i++) begin
                    active_r[i] <= shadow_r[i];
                end
                ccount_r <= ccount_r + 8'd1;
            end
        end
    end

    // Control register: not shadowed, applies on the next cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            en_r   <= 1'b1;
            byp1_r <= 1'b0;
            byp2_r <= 1'b0;
        end else if (wr_ok_s && (PADDR == 5'd10)) begin
            en_r   <= PWDATA[0];
            byp1_r <= PWDATA[1];
            byp2_r <= PWDATA[2];
        end
    end

    assign coeff_1     = {active_r[0], active_r[1], active_r[2], active_r[3], active_r[4]};
    assign coeff_2     = {active_r[5], active_r[6], active_r[7], active_r[8], active_r[9]};
    assign EN          = en_r;
    assign bypass_1    = byp1_r;
    assign bypass_2    = byp2_r;
    assign commit_done = done_r;
    assign PRDATA      = rdata_s;
    assign PSLVERR     = err_s;
    assign PREADY      = 1'b1;

endmodule

// File: tb/tb_notch_coeff_loader.sv
// tb_notch_coeff_loader
// Directed bench with a register-map model; a per-cycle compare process
// checks the registered outputs, and APB reads/errors are checked per access.
module tb_notch_coeff_loader;

    logic        CLK_tb = 1'b0;
    logic        rst;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        sample_strobe;
    logic [79:0] coeff_1;
    logic [79:0] coeff_2;
    logic        EN;
    logic        bypass_1;
    logic        bypass_2;
    logic        commit_done;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] DEF [10] = '{16'h4000, 16'h678E, 16'h4000, 16'h6473, 16'h3C38,
                                         16'h4000, 16'hC000, 16'h4000, 16'hC1EC, 16'h3C38};

    // Model of the register map
    logic [15:0] m_shadow [10];
    logic [15:0] m_active [10];
    logic        m_en, m_b1, m_b2, m_pend, m_done;
    logic [7:0]  m_cnt;
    logic        m_valid = 1'b0;

    notch_coeff_loader #(.width(16)) dut (
        .CLK(CLK_tb), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .sample_strobe(sample_strobe), .coeff_1(coeff_1),
        .coeff_2(coeff_2), .EN(EN), .bypass_1(bypass_1), .bypass_2(bypass_2),
        .commit_done(commit_done)
    );

    // Free-running clock.
    always #5 CLK_tb = ~CLK_tb;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic [4:0] addr, input logic wr);
        return (addr > 5'd12) || (wr && addr == 5'd12) || (wr && addr < 5'd10 && m_pend);
    endfunction

    function automatic logic [15:0] exp_rdata(input logic [4:0] addr);
        if (addr < 5'd10)  return m_shadow[addr[3:0]];
        if (addr == 5'd10) return {13'd0, m_b2, m_b1, m_en};
        if (addr == 5'd11) return {15'd0, m_pend};
        if (addr == 5'd12) return {8'd0, m_cnt};
        return 16'h0000;
    endfunction

    function automatic logic [79:0] m_pack(input int base);
        return {m_active[base], m_active[base+1], m_active[base+2], m_active[base+3], m_active[base+4]};
    endfunction

    // Model update: applies the register-map rules to the inputs seen at each edge.
    always @(posedge CLK_tb) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                m_shadow[i] <= DEF[i];
                m_active[i] <= DEF[i];
            end
            m_en <= 1'b1; m_b1 <= 1'b0; m_b2 <= 1'b0;
            m_pend <= 1'b0; m_done <= 1'b0; m_cnt <= 8'd0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_done <= 1'b0;
            if (PSEL && PENABLE && PWRITE && !exp_err(PADDR, PWRITE)) begin
                if (PADDR < 5'd10) m_shadow[PADDR[3:0]] <= PWDATA;
                else if (PADDR == 5'd10) {m_b2, m_b1, m_en} <= PWDATA[2:0];
                else if (PADDR == 5'd11 && PWDATA[0] && !m_pend) m_pend <= 1'b1;
            end
            if (m_pend && sample_strobe) begin
                for (int i = 0; i < 10; i++) m_active[i] <= m_shadow[i];
                m_done <= 1'b1;
                m_cnt  <= m_cnt + 8'd1;
                m_pend <= 1'b0;
            end
        end
    end

    // Per-cycle compare of registered outputs against the model.
    always @(negedge CLK_tb) begin
        if (m_valid) begin
            check("coeff_1", coeff_1, m_pack(0));
            check("coeff_2", coeff_2, m_pack(5));
            check("EN", 80'(EN), 80'(m_en));
            check("bypass_1", 80'(bypass_1), 80'(m_b1));
            check("bypass_2", 80'(bypass_2), 80'(m_b2));
            check("commit_done", 80'(commit_done), 80'(m_done));
            check("PREADY", 80'(PREADY), 80'd1);
        end
    end

    task automatic apb(input logic wr, input logic [4:0] addr, input logic [15:0] wd,
                       input logic strb, output logic [15:0] rd, output logic er);
        logic        e_er;
        logic [15:0] e_rd;
        @(negedge CLK_tb);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        #1;
        check("prdata_setup", 80'(PRDATA), 80'd0);
        check("pslverr_setup", 80'(PSLVERR), 80'd0);
        @(negedge CLK_tb);
        PENABLE = 1'b1; sample_strobe = strb;
        #1;
        e_er = exp_err(addr, wr);
        e_rd = (wr || e_er) ? 16'h0000 : exp_rdata(addr);
        check("pslverr", 80'(PSLVERR), 80'(e_er));
        check("prdata", 80'(PRDATA), 80'(e_rd));
        rd = PRDATA;
        er = PSLVERR;
        @(negedge CLK_tb);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; sample_strobe = 1'b0;
    endtask

    task automatic strobe();
        @(negedge CLK_tb);
        sample_strobe = 1'b1;
        @(negedge CLK_tb);
        sample_strobe = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;

    // Directed stimulus with literal expectations.
    initial begin
        rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 5'd0; PWDATA = 16'h0000; sample_strobe = 1'b0;
        repeat (2) @(negedge CLK_tb);
        rst = 1'b0;

        // Reset state
        check("rst_coeff_1", coeff_1, 80'h4000678E400064733C38);
        check("rst_coeff_2", coeff_2, 80'h4000C0004000C1EC3C38);
        check("rst_en_byp", 80'({EN, bypass_1, bypass_2}), 80'd4);
        apb(1'b0, 5'd12, 16'h0000, 1'b0, rd, er);
        check("rst_ccount", 80'(rd), 80'd0);

        // Shadow write, readback, commit
        apb(1'b1, 5'd1, 16'h1234, 1'b0, rd, er);
        apb(1'b0, 5'd1, 16'h0000, 1'b0, rd, er);
        check("shadow_rb", 80'(rd), 80'h1234);
        check("active_unch", coeff_1, 80'h4000678E400064733C38);
        apb(1'b1, 5'd11, 16'h0001, 1'b0, rd, er);
        strobe();
        check("commit_c1", coeff_1, 80'h40001234400064733C38);
        check("commit_done_hi", 80'(commit_done), 80'd1);
        @(negedge CLK_tb);
        check("commit_done_lo", 80'(commit_done), 80'd0);
        apb(1'b0, 5'd12, 16'h0000, 1'b0, rd, er);
        check("ccount_1", 80'(rd), 80'd1);

        // COMMIT with bit0=0 in IDLE does nothing
        apb(1'b1, 5'd11, 16'h0000, 1'b0, rd, er);
        apb(1'b0, 5'd11, 16'h0000, 1'b0, rd, er);
        check("commit0_idle", 80'(rd), 80'd0);

        // Strobe in the same cycle as COMMIT does not commit
        apb(1'b1, 5'd11, 16'h0001, 1'b1, rd, er);
        check("same_cycle_no_done", 80'(commit_done), 80'd0);
        apb(1'b0, 5'd11, 16'h0000, 1'b0, rd, er);
        check("pending_set", 80'(rd), 80'd1);
        strobe();
        check("late_commit_done", 80'(commit_done), 80'd1);
        apb(1'b0, 5'd11, 16'h0000, 1'b0, rd, er);
        check("pending_clr", 80'(rd), 80'd0);

        // Errors while pending and out of range
        apb(1'b1, 5'd11, 16'h0001, 1'b0, rd, er);
        apb(1'b1, 5'd7, 16'hAAAA, 1'b0, rd, er);
        check("wr_pending_err", 80'(er), 80'd1);
        apb(1'b0, 5'd7, 16'h0000, 1'b0, rd, er);
        check("shadow7_unch", 80'(rd), 80'h4000);
        apb(1'b0, 5'd13, 16'h0000, 1'b0, rd, er);
        check("rd_0d_err", 80'({er, rd}), 80'h10000);
        apb(1'b1, 5'd13, 16'h5555, 1'b0, rd, er);
        check("wr_0d_err", 80'({er, rd}), 80'h10000);
        apb(1'b1, 5'd12, 16'h00FF, 1'b0, rd, er);
        check("wr_0c_err", 80'({er, rd}), 80'h10000);
        apb(1'b1, 5'd11, 16'h0000, 1'b0, rd, er);
        strobe();
        apb(1'b0, 5'd12, 16'h0000, 1'b0, rd, er);
        check("ccount_3", 80'(rd), 80'd3);

        // CTRL applies directly
        apb(1'b1, 5'd10, 16'h0006, 1'b0, rd, er);
        check("ctrl_apply", 80'({EN, bypass_1, bypass_2}), 80'd3);
        apb(1'b0, 5'd10, 16'h0000, 1'b0, rd, er);
        check("ctrl_rb", 80'(rd), 80'd6);

        // Strobe in IDLE changes nothing
        strobe();
        check("idle_strobe", 80'(commit_done), 80'd0);

        // Run the commit counter through its wrap
        for (int i = 0; i < 253; i++) begin
            apb(1'b1, 5'd0, 16'(i * 3), 1'b0, rd, er);
            apb(1'b1, 5'd11, 16'h0001, 1'b0, rd, er);
            strobe();
        end
        apb(1'b0, 5'd12, 16'h0000, 1'b0, rd, er);
        check("ccount_wrap", 80'(rd), 80'd0);
        check("last_b0", coeff_1[79:64], 80'(16'd756));

        // Reset while pending discards the commit; APB ignored during reset
        apb(1'b1, 5'd11, 16'h0001, 1'b0, rd, er);
        @(negedge CLK_tb);
        rst = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 5'd13;
        #1;
        check("rst_apb_err", 80'({PSLVERR, PRDATA}), 80'd0);
        @(negedge CLK_tb);
        rst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        strobe();
        check("rst_no_done", 80'(commit_done), 80'd0);
        @(negedge CLK_tb);
        check("rst_no_done2", 80'(commit_done), 80'd0);
        check("rst_def_c1", coeff_1, 80'h4000678E400064733C38);
        check("rst_def_c2", coeff_2, 80'h4000C0004000C1EC3C38);
        check("rst_ctrl", 80'({EN, bypass_1, bypass_2}), 80'd4);
        repeat (2) @(negedge CLK_tb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
